// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-cache miss sequencer: freezes upstream pipeline registers and bubbles MEM/WB until the line refill lands.
// Define MEM_STALL_STATS_EN to add saturating miss_cnt / stall_cyc statistics outputs.
module mem_stall_ctrl #(
    parameter int MISS_PENALTY = 4,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic mem_ready,
    output logic mem_req,
    output logic refill_we,
    output logic stall,
    output logic pipe_en,
    output logic wb_bubble,
    output logic busy
`ifdef MEM_STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] stall_cyc
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        REFILL = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MISS_PENALTY - 1);

    if (MISS_PENALTY < 1 || MISS_PENALTY > 255 || CNT_W < 1) begin : g_param_check
        $error("mem_stall_ctrl: MISS_PENALTY must be 1..255 and CNT_W >= 1");
    end

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       access;
    logic       miss_start;

    assign access = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // mem_ready only matters once the minimum penalty has fully elapsed
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        miss_start = 1'b0;
        case (state)
            IDLE: begin
                if (access && !hit) begin
                    state_nxt  = REQ;
                    miss_start = 1'b1;
                end
            end
            REQ: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (mem_ready) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while rst is high so an aborted miss never strobes refill_we
    always_comb begin
        busy      = 1'b0;
        mem_req   = 1'b0;
        refill_we = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            busy      = (state != IDLE);
            mem_req   = (state == REQ);
            refill_we = (state == REFILL);
            stall     = (state != IDLE) | miss_start;
        end
        pipe_en   = ~stall;
        wb_bubble = stall;
    end

`ifdef MEM_STALL_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt  <= '0;
            stall_cyc <= '0;
        end else begin
            miss_cnt  <= sat_inc(miss_cnt, miss_start);
            stall_cyc <= sat_inc(stall_cyc, stall);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl (MISS_PENALTY=4): expected output vectors are queued per cycle and popped at sample time.
module tb_mem_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic mem_read;
    logic mem_write;
    logic hit;
    logic mem_ready;
    logic mem_req;
    logic refill_we;
    logic stall;
    logic pipe_en;
    logic wb_bubble;
    logic busy;
`ifdef MEM_STALL_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] stall_cyc;
    logic        mem_req4;
    logic        refill_we4;
    logic        stall4;
    logic        pipe_en4;
    logic        wb_bubble4;
    logic        busy4;
    logic [3:0]  miss_cnt4;
    logic [3:0]  stall_cyc4;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [5:0] exp_q[$];
    logic [5:0] got;
    logic [5:0] want;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.MISS_PENALTY(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .mem_ready(mem_ready), .mem_req(mem_req), .refill_we(refill_we),
        .stall(stall), .pipe_en(pipe_en), .wb_bubble(wb_bubble), .busy(busy)
`ifdef MEM_STALL_STATS_EN
        , .miss_cnt(miss_cnt), .stall_cyc(stall_cyc)
`endif
    );

`ifdef MEM_STALL_STATS_EN
    mem_stall_ctrl #(.MISS_PENALTY(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .hit(hit), .mem_ready(mem_ready), .mem_req(mem_req4), .refill_we(refill_we4),
        .stall(stall4), .pipe_en(pipe_en4), .wb_bubble(wb_bubble4), .busy(busy4),
        .miss_cnt(miss_cnt4), .stall_cyc(stall_cyc4)
    );
`endif

    // Vector layout: {stall, pipe_en, wb_bubble, mem_req, refill_we, busy}
    function automatic logic [5:0] mk(input logic s, input logic mr, input logic rw, input logic b);
        return {s, ~s, s, mr, rw, b};
    endfunction

    // Miss timeline for MISS_PENALTY=4: miss cycle, REQ, 4x WAIT, REFILL
    function automatic logic [5:0] miss_phase(input int p);
        case (p)
            0:       return mk(1'b1, 1'b0, 1'b0, 1'b0);
            1:       return mk(1'b1, 1'b1, 1'b0, 1'b1);
            6:       return mk(1'b1, 1'b0, 1'b1, 1'b1);
            default: return mk(1'b1, 1'b0, 1'b0, 1'b1);
        endcase
    endfunction

    task automatic apply(input logic r, input logic rd, input logic wr, input logic h,
                         input logic rdy, input logic [5:0] e);
        rst       = r;
        mem_read  = rd;
        mem_write = wr;
        hit       = h;
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0, 1:    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
                2:       apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
                default: apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
            endcase
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hit();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 1'(i % 2), mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL hit cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)
                apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, miss_phase(0));
            else if (i < 7)
                apply(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1, miss_phase(i));
            else
                apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL miss cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_late_memory();
        logic       rdy;
        logic [5:0] e;
        for (int i = 0; i < 13; i++) begin
            rdy = (i >= 2 && i <= 4) || (i >= 10);
            if (i == 0)       e = miss_phase(0);
            else if (i == 1)  e = miss_phase(1);
            else if (i <= 10) e = mk(1'b1, 1'b0, 1'b0, 1'b1);
            else if (i == 11) e = miss_phase(6);
            else              e = mk(1'b0, 1'b0, 1'b0, 1'b0);
            apply(1'b0, 1'b1, 1'b0, (i == 12), rdy, e);
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL late_mem cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 1'b1, 1'b1, (i == 14), 1'b1,
                  (i < 14) ? miss_phase(i % 7) : mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_miss();
        // Abort in WAIT with cnt=2, then idle with mem_ready high
        for (int i = 0; i < 10; i++) begin
            if (i < 3)       apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, miss_phase(i));
            else if (i == 3) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0));
            else             apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_wait cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        // Abort exactly in the REFILL cycle: refill_we must stay low
        for (int i = 0; i < 8; i++) begin
            if (i < 6)       apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, miss_phase(i));
            else if (i == 6) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
            else             apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_in_refill cyc %0d: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef MEM_STALL_STATS_EN
    task automatic test_stats();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
        want = exp_q.pop_front();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL stats_reset: got %b want %b", got, want);
        end
        @(posedge clk); #1;
        vectors++;
        if (miss_cnt !== 16'd0 || stall_cyc !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_cleared: miss_cnt %0d stall_cyc %0d want 0 0", miss_cnt, stall_cyc);
        end
        for (int i = 0; i < 22; i++) begin
            apply(1'b0, 1'b1, 1'b0, (i == 21), 1'b1,
                  (i < 21) ? miss_phase(i % 7) : mk(1'b0, 1'b0, 1'b0, 1'b0));
            #1;
            got  = {stall, pipe_en, wb_bubble, mem_req, refill_we, busy};
            want = exp_q.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stats_seq cyc %0d: got %b want %b", i, got, want);
            end
            if (i == 14) begin
                vectors++;
                if (miss_cnt !== 16'd2 || stall_cyc !== 16'd14) begin
                    miscompares++;
                    $display("FAIL stats_two_miss: miss_cnt %0d stall_cyc %0d want 2 14", miss_cnt, stall_cyc);
                end
                vectors++;
                if (miss_cnt4 !== 4'd2 || stall_cyc4 !== 4'd14) begin
                    miscompares++;
                    $display("FAIL stats4_two_miss: miss_cnt %0d stall_cyc %0d want 2 14", miss_cnt4, stall_cyc4);
                end
            end
            if (i == 21) begin
                vectors++;
                if (miss_cnt !== 16'd3 || stall_cyc !== 16'd21) begin
                    miscompares++;
                    $display("FAIL stats_three_miss: miss_cnt %0d stall_cyc %0d want 3 21", miss_cnt, stall_cyc);
                end
                vectors++;
                if (miss_cnt4 !== 4'd3 || stall_cyc4 !== 4'd15) begin
                    miscompares++;
                    $display("FAIL stats4_saturate: miss_cnt %0d stall_cyc %0d want 3 15", miss_cnt4, stall_cyc4);
                end
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 1'b0;
        mem_ready = 1'b0;
        #1;
        test_reset();
        test_hit();
        test_miss();
        test_late_memory();
        test_back_to_back();
        test_reset_mid_miss();
`ifdef MEM_STALL_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Sequences the MEM stage on a data-cache miss. Freezes the upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM) and injects bubbles into MEM/WB until the refill completes.
- Sits between the data cache (hit), main memory (mem_req/mem_ready) and the pipeline-register enables.
- Enforces a fixed minimum miss penalty with a down-counter, then waits on the memory handshake.

Parameters:
- MISS_PENALTY, 4, minimum WAIT cycles per miss; legal range 1..255.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  MEM-stage instruction is a load.
- mem_write  input  1  MEM-stage instruction is a store.
- hit  input  1  data-cache hit for the current MEM-stage address.
- mem_ready  input  1  main memory has refill data available.
- mem_req  output  1  one-cycle refill request to main memory.
- refill_we  output  1  one-cycle cache line write strobe.
- stall  output  1  freeze PC/IF_ID/ID_EX/EX_MEM (hold contents).
- pipe_en  output  1  equals ~stall.
- wb_bubble  output  1  MEM/WB captures a bubble (reg_write=0, mem_to_reg=0).
- busy  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, REQ, WAIT, REFILL; 2-bit encoding. An 8-bit down-counter cnt.
- Reset:
  - state=IDLE, cnt=0.
  - mem_req=0, refill_we=0, busy=0.
  - stall=0, pipe_en=1, wb_bubble=0.
  - Stats counters cleared.
  - rst asserted in any state, mid-miss included, aborts the miss with no refill_we pulse.
- Define access = mem_read | mem_write.
- IDLE:
  - If access & ~hit, go to REQ.
  - Otherwise stay in IDLE; hit is ignored when access=0.
- REQ: mem_req=1 for exactly this cycle; cnt <= MISS_PENALTY-1; go to WAIT.
- WAIT:
  - If cnt!=0, cnt <= cnt-1.
  - Else if mem_ready, go to REFILL.
  - Else hold, with no timeout.
  - mem_ready is sampled only when cnt==0; early readiness is ignored.
- REFILL: refill_we=1 for exactly this cycle; go to IDLE.
- stall, combinational: (state!=IDLE) | (state==IDLE & access & ~hit). The miss cycle itself is stalled, with no one-cycle slip.
- wb_bubble = stall. busy = (state!=IDLE). mem_req and refill_we are registered-state decodes (Moore).
- Miss latency with mem_ready already high: stall high for MISS_PENALTY+3 consecutive cycles (miss cycle, REQ, MISS_PENALTY WAIT cycles, REFILL).
- Return to IDLE:
  - The held instruction re-presents. The cache now hits, so stall drops that cycle.
  - If hit is still 0 (e.g. conflict eviction), a new miss starts immediately, with no idle gap.
- mem_read and mem_write both high: treated as a single access.
- Inputs changing while not in IDLE are ignored, except mem_ready in WAIT.

Optional Feature:
- Macro: MEM_STALL_STATS_EN.
- When defined, adds two outputs:
  - miss_cnt[CNT_W-1:0]: +1 on each IDLE->REQ transition.
  - stall_cyc[CNT_W-1:0]: +1 on every cycle with stall=1.
- Both saturate at all-ones and are cleared by rst.
- When undefined, neither the ports nor the logic exist.

Test Plan:
- Reset: rst=1 for 2 cycles, with mem_read=1, hit=0 -> stall=0, pipe_en=1, mem_req=0, busy=0 throughout reset. First cycle after release: stall=1.
- Hit path: mem_read=1, hit=1 for 10 cycles -> stall=0, mem_req never pulses, busy=0.
- Miss, MISS_PENALTY=4, mem_ready tied 1:
  - mem_write=1, hit=0 at cycle t -> stall=1 for cycles t..t+6 (7 cycles).
  - mem_req=1 only at t+1; refill_we=1 only at t+6.
  - hit=1 at t+7 -> stall=0.
- Late memory: miss with mem_ready=0 until 5 cycles after cnt reaches 0 -> FSM holds in WAIT, stall stays 1. REFILL occurs the cycle after mem_ready rises; total stall = 4+3+5 = 12 cycles.
- Reset mid-miss: rst=1 during WAIT (cnt=2) -> next cycle state=IDLE, stall=0 (given access=0), no refill_we pulse.
- Stats (MEM_STALL_STATS_EN): two back-to-back misses with MISS_PENALTY=4, ready=1 -> miss_cnt=2, stall_cyc=14. Force CNT_W=4 with 3 misses -> stall_cyc saturates at 15.
